// File: rtl/decision_tree.sv
// Fixed five-node binary decision-tree classifier over IEEE-754 single-precision
// features. Walks one node per clock and strobes a 3-bit class label on completion.
module decision_tree #(
  parameter logic [31:0] T0 = 32'h3F800000,
  parameter logic [31:0] T1 = 32'h40000000,
  parameter logic [31:0] T2 = 32'h40400000,
  parameter logic [31:0] T3 = 32'h40800000,
  parameter logic [31:0] T4 = 32'h40A00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] feature0,
  input  logic [31:0] feature1,
  input  logic [31:0] feature2,
  input  logic [31:0] feature3,
  input  logic [31:0] feature4,
  // "class" is a reserved word, so the label port is class_label.
  output logic [2:0]  class_label,
  output logic        busy,
  output logic        valid,
  output logic        dbg_state,
  output logic [2:0]  dbg_node
);

  // Handshake: start is sampled only while idle (busy=0); valid is a one-cycle
  // strobe with class_label, which then holds until the next result or reset.

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  typedef struct packed {
    logic       leaf;
    logic [2:0] idx;
  } child_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  node;
  logic [2:0]  node_next;
  logic [2:0]  class_next;
  logic        busy_next;
  logic        valid_next;
  logic        load;
  logic [31:0] feat_q [5];

  logic [31:0] sel_feature;
  logic [31:0] sel_threshold;
  logic        go_left;
  child_t      child;

  function automatic logic is_nan(input logic [31:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    is_zero = (x[30:0] == 31'd0);
  endfunction

  // a <= b on raw IEEE-754 encodings; sign-magnitude ordering, no flush-to-zero.
  function automatic logic fp_le(input logic [31:0] a, input logic [31:0] b);
    fp_le = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      fp_le = 1'b0;
    end else if (is_zero(a) && is_zero(b)) begin
      fp_le = 1'b1;
    end else begin
      unique case ({a[31], b[31]})
        2'b00:   fp_le = (a[30:0] <= b[30:0]);
        2'b11:   fp_le = (a[30:0] >= b[30:0]);
        2'b10:   fp_le = 1'b1;
        default: fp_le = 1'b0;
      endcase
    end
  endfunction

  // Node i always tests feature i against threshold Ti.
  always_comb begin
    sel_feature   = 32'd0;
    sel_threshold = 32'd0;
    unique case (node)
      3'd0: begin sel_feature = feat_q[0]; sel_threshold = T0; end
      3'd1: begin sel_feature = feat_q[1]; sel_threshold = T1; end
      3'd2: begin sel_feature = feat_q[2]; sel_threshold = T2; end
      3'd3: begin sel_feature = feat_q[3]; sel_threshold = T3; end
      3'd4: begin sel_feature = feat_q[4]; sel_threshold = T4; end
      default: begin sel_feature = 32'd0; sel_threshold = 32'd0; end
    endcase
  end

  assign go_left = fp_le(sel_feature, sel_threshold);

  // Tree topology. Unreachable node codes fall out as a leaf so EVAL cannot stick.
  always_comb begin
    child = '{leaf: 1'b1, idx: 3'd0};
    unique case (node)
      3'd0: child = go_left ? '{leaf: 1'b0, idx: 3'd1} : '{leaf: 1'b0, idx: 3'd2};
      3'd1: child = go_left ? '{leaf: 1'b0, idx: 3'd3} : '{leaf: 1'b1, idx: 3'd1};
      3'd2: child = go_left ? '{leaf: 1'b1, idx: 3'd2} : '{leaf: 1'b0, idx: 3'd4};
      3'd3: child = go_left ? '{leaf: 1'b1, idx: 3'd0} : '{leaf: 1'b1, idx: 3'd3};
      3'd4: child = go_left ? '{leaf: 1'b1, idx: 3'd4} : '{leaf: 1'b1, idx: 3'd5};
      default: child = '{leaf: 1'b1, idx: 3'd0};
    endcase
  end

  always_comb begin
    state_next = state;
    node_next  = node;
    class_next = class_label;
    busy_next  = busy;
    valid_next = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          node_next  = 3'd0;
          busy_next  = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (child.leaf) begin
          class_next = child.idx;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          node_next = child.idx;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      node        <= 3'd0;
      class_label <= 3'd0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      for (int i = 0; i < 5; i++) feat_q[i] <= 32'd0;
    end else begin
      node        <= node_next;
      class_label <= class_next;
      busy        <= busy_next;
      valid       <= valid_next;
      if (load) begin
        feat_q[0] <= feature0;
        feat_q[1] <= feature1;
        feat_q[2] <= feature2;
        feat_q[3] <= feature3;
        feat_q[4] <= feature4;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_node  = node;

endmodule

// File: tb/tb_decision_tree.sv
// Randomized and directed bench for decision_tree: a driver pushes reference-model
// results into a queue and a negedge monitor pops and compares on every valid.
module tb_decision_tree;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] feature0, feature1, feature2, feature3, feature4;
  logic [2:0]  class_label;
  logic        busy;
  logic        valid;
  logic        dbg_state;
  logic [2:0]  dbg_node;

  decision_tree dut (
    .clk(clk), .rst(rst), .start(start),
    .feature0(feature0), .feature1(feature1), .feature2(feature2),
    .feature3(feature3), .feature4(feature4),
    .class_label(class_label), .busy(busy), .valid(valid),
    .dbg_state(dbg_state), .dbg_node(dbg_node)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  int         lat_q[$];
  logic [2:0] last_class = 3'd0;
  logic [2:0] m_exp;
  int         m_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cyc=%0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] thr[5]    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  // Child codes: >=0 is the next node, <0 is leaf class (-code-1).
  int          left_c[5]  = '{1, 3, -3, -1, -5};
  int          right_c[5] = '{2, -2, 4, -4, -6};

  function automatic bit f_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Map an encoding onto a signed number line: -mag for negatives, so -0 == +0.
  function automatic longint f_key(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic bit f_le(input logic [31:0] a, input logic [31:0] b);
    if (f_nan(a) || f_nan(b)) return 1'b0;
    return f_key(a) <= f_key(b);
  endfunction

  task automatic model(input logic [31:0] f[5], output logic [2:0] cls, output int depth);
    int n;
    int nxt;
    n = 0;
    depth = 0;
    cls = 3'd0;
    for (int k = 0; k < 5; k++) begin
      depth++;
      nxt = f_le(f[n], thr[n]) ? left_c[n] : right_c[n];
      if (nxt < 0) begin
        cls = 3'(-nxt - 1);
        break;
      end
      n = nxt;
    end
  endtask

  task automatic expect_result(input logic [31:0] f[5], input int start_edge);
    logic [2:0] cls;
    int d;
    model(f, cls, d);
    exp_q.push_back(cls);
    lat_q.push_back(start_edge + d);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_class = 3'd0;
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        m_lat = lat_q.pop_front();
        check("class", 32'(class_label), 32'(m_exp));
        check("latency_edge", cyc, m_lat);
        check("busy_at_valid", 32'(busy), 32'd0);
        last_class = m_exp;
      end
    end else begin
      check("class_hold", 32'(class_label), 32'(last_class));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] f[5]);
    feature0 = f[0]; feature1 = f[1]; feature2 = f[2]; feature3 = f[3]; feature4 = f[4];
  endtask

  task automatic scramble();
    feature0 = $urandom(); feature1 = $urandom(); feature2 = $urandom();
    feature3 = $urandom(); feature4 = $urandom();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic send5(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic [31:0] e);
    logic [31:0] f[5];
    f = '{a, b, c, d, e};
    wait_idle();
    @(negedge clk);
    drive(f);
    start = 1'b1;
    @(posedge clk);
    #1;
    expect_result(f, cyc);
    check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  // start held high through the valid edge: second request lands one edge later.
  task automatic hold_two(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d, input logic [31:0] e);
    logic [31:0] f[5];
    logic [2:0]  cls;
    int          depth;
    f = '{a, b, c, d, e};
    model(f, cls, depth);
    wait_idle();
    @(negedge clk);
    drive(f);
    start = 1'b1;
    @(posedge clk);
    #1;
    expect_result(f, cyc);
    repeat (depth + 1) @(posedge clk);
    #1;
    expect_result(f, cyc);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  function automatic logic [31:0] rfeat(input int i);
    case ($urandom_range(0, 9))
      0: return $urandom();
      1: return thr[i];
      2: return thr[i] + 32'd1;
      3: return thr[i] - 32'd1;
      4: return 32'h80000000 | $urandom();
      5: return 32'h7FC00000 | ($urandom() & 32'h803FFFFF);
      6: return $urandom_range(0, 1) ? 32'hFF800000 : 32'h7F800000;
      7: return $urandom_range(0, 1) ? 32'h00000000 : 32'h80000000;
      default: return {1'b0, 8'(8'd126 + 8'($urandom_range(0, 3))), 23'($urandom())};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    feature0 = '0; feature1 = '0; feature2 = '0; feature3 = '0; feature4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_class", 32'(class_label), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send5(32'h3F000000, 32'h40400000, 32'h0, 32'h0, 32'h0);          // class 1, depth 2
    send5(32'h3F000000, 32'h3F800000, 32'h0, 32'h40800000, 32'h0);   // f3 == T3 -> class 0
    send5(32'h3F000000, 32'h3F800000, 32'h0, 32'h40800001, 32'h0);   // class 3
    send5(32'h40000000, 32'h0, 32'h40400000, 32'h0, 32'h0);          // class 2, depth 2
    send5(32'h40000000, 32'h0, 32'h40600000, 32'h0, 32'hBF800000);   // class 4
    send5(32'h40000000, 32'h0, 32'h40600000, 32'h0, 32'h7F800000);   // +inf -> class 5
    send5(32'h80000000, 32'h40400000, 32'h0, 32'h0, 32'h0);          // -0 left -> class 1
    send5(32'h7FC00000, 32'h0, 32'h0, 32'h0, 32'h0);                 // NaN right -> class 2

    // Second start while busy must be dropped.
    send5(32'h3F000000, 32'h3F800000, 32'h0, 32'h40800001, 32'h0);
    feature0 = 32'h40000000; feature2 = 32'h40600000; feature4 = 32'h7F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_during_ignored_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;

    // Reset mid-evaluation aborts the request silently.
    send5(32'h40000000, 32'h0, 32'h40600000, 32'h0, 32'hBF800000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    lat_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_class", 32'(class_label), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    hold_two(32'h3F000000, 32'h40400000, 32'h0, 32'h0, 32'h0);
    hold_two(32'h40000000, 32'h0, 32'h40600000, 32'h0, 32'h40A00000);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        hold_two(rfeat(0), rfeat(1), rfeat(2), rfeat(3), rfeat(4));
      else
        send5(rfeat(0), rfeat(1), rfeat(2), rfeat(3), rfeat(4));
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
